// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state encoding and select constants for the 2:1 burst arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_A = 2'd1,
    ARB_GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arb_burst_cnt.sv
// rtl/mux_arb_burst_cnt.sv - per-grant beat counter that flags the MAX_BURST-th transfer
module mux_arb_burst_cnt #(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic xfer,
  input  logic burst_end,
  output logic limit
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (burst_end) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds transfers already done, so the current one is the MAX_BURST-th when cnt == MAX_BURST-1
  assign limit = xfer && (cnt == CW'(MAX_BURST - 1));

endmodule

// File: rtl/mux_arb_2to1.sv
// rtl/mux_arb_2to1.sv - round-robin burst arbiter driving the mux_2to1 select; MUX_ARB_TIMEOUT_EN enables MAX_BURST cut-off
module mux_arb_2to1
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic last_a,
  input  logic req_b,
  input  logic last_b,
  input  logic ready,
  output logic grant_a,
  output logic grant_b,
  output logic sel,
  output logic valid
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mux_arb_2to1: MAX_BURST must be within 1..255");
  end

  arb_state_t state, state_n;
  logic       prio, prio_n;
  logic       sel_n;
  logic       xfer;
  logic       last_cur;
  logic       limit;
  logic       burst_end;

  assign valid     = (grant_a & req_a) | (grant_b & req_b);
  assign xfer      = valid & ready;
  assign last_cur  = grant_b ? last_b : last_a;
  assign burst_end = xfer & (last_cur | limit);

`ifdef MUX_ARB_TIMEOUT_EN
  mux_arb_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clk       (clk),
    .rst       (rst),
    .xfer      (xfer),
    .burst_end (burst_end),
    .limit     (limit)
  );
`else
  assign limit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    prio_n  = prio;
    sel_n   = sel;
    case (state)
      ARB_IDLE: begin
        if (req_a && (!req_b || !prio)) begin
          state_n = ARB_GNT_A;
        end else if (req_b) begin
          state_n = ARB_GNT_B;
        end
      end
      ARB_GNT_A: begin
        if (burst_end) begin
          prio_n = 1'b1;
          if (req_b) begin
            state_n = ARB_GNT_B;
          end else if (!req_a) begin
            state_n = ARB_IDLE;
          end
        end
      end
      ARB_GNT_B: begin
        if (burst_end) begin
          prio_n = 1'b0;
          if (req_a) begin
            state_n = ARB_GNT_A;
          end else if (!req_b) begin
            state_n = ARB_IDLE;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
    // IDLE keeps the last select so the downstream mux output does not toggle
    if (state_n == ARB_GNT_A) begin
      sel_n = SEL_A;
    end else if (state_n == ARB_GNT_B) begin
      sel_n = SEL_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      prio    <= 1'b0;
      sel     <= SEL_A;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
    end else begin
      state   <= state_n;
      prio    <= prio_n;
      sel     <= sel_n;
      grant_a <= (state_n == ARB_GNT_A);
      grant_b <= (state_n == ARB_GNT_B);
    end
  end

endmodule

// File: tb/tb_mux_arb_2to1.sv
// tb/tb_mux_arb_2to1.sv - self-checking bench for mux_arb_2to1 against a behavioural owner/priority model
module tb_mux_arb_2to1;

  localparam int MAXB = 3;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int LOCK_LEN = TMO ? MAXB : 4;

  logic clk = 1'b0;
  logic rst, req_a, last_a, req_b, last_b, ready;
  logic grant_a, grant_b, sel, valid;

  int n_checks = 0;
  int n_pass   = 0;

  // model: owner 0 = nobody, 1 = A, 2 = B
  int m_own  = 0;
  bit m_prio = 1'b0;
  bit m_sel  = 1'b0;
  int m_cnt  = 0;

  mux_arb_2to1 #(.MAX_BURST(MAXB)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .last_a  (last_a),
    .req_b   (req_b),
    .last_b  (last_b),
    .ready   (ready),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .sel     (sel),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    return (m_own == 1 && req_a) || (m_own == 2 && req_b);
  endfunction

  function automatic logic [3:0] m_vec();
    return {m_own == 1, m_own == 2, m_sel, m_valid()};
  endfunction

  task automatic tick();
    int own_n, cnt_n;
    bit prio_n, sel_n, lastx, other_req, own_req;
    own_n = m_own; cnt_n = m_cnt; prio_n = m_prio; sel_n = m_sel;
    if (rst) begin
      own_n = 0; prio_n = 1'b0; sel_n = 1'b0; cnt_n = 0;
    end else if (m_own == 0) begin
      if (req_a && req_b) own_n = m_prio ? 2 : 1;
      else if (req_a) own_n = 1;
      else if (req_b) own_n = 2;
    end else if (m_valid() && ready) begin
      cnt_n = m_cnt + 1;
      lastx = (m_own == 1) ? last_a : last_b;
      if (lastx || (TMO && cnt_n >= MAXB)) begin
        cnt_n     = 0;
        prio_n    = (m_own == 1);
        other_req = (m_own == 1) ? req_b : req_a;
        own_req   = (m_own == 1) ? req_a : req_b;
        own_n     = other_req ? 3 - m_own : (own_req ? m_own : 0);
      end
    end
    if (own_n == 1) sel_n = 1'b0;
    else if (own_n == 2) sel_n = 1'b1;
    @(posedge clk);
    m_own = own_n; m_cnt = cnt_n; m_prio = prio_n; m_sel = sel_n;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0; ready = 1'b1;
    tick(); tick();
    #1;
    n_checks++; if (grant_a !== 1'b0) $display("FAIL reset_grant_a: got %b want 0", grant_a); else n_pass++;
    n_checks++; if (grant_b !== 1'b0) $display("FAIL reset_grant_b: got %b want 0", grant_b); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", sel); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    rst = 1'b0;
    tick();
    #1;
    n_checks++; if (grant_a !== 1'b1) $display("FAIL reset_first_grant_a: got %b want 1", grant_a); else n_pass++;
    n_checks++; if (grant_b !== 1'b0) $display("FAIL reset_first_grant_b: got %b want 0", grant_b); else n_pass++;
    n_checks++; if ({grant_a, grant_b, sel, valid} !== m_vec())
      $display("FAIL reset_model: got %b want %b", {grant_a, grant_b, sel, valid}, m_vec()); else n_pass++;
  endtask

  task automatic test_tie_rr();
    logic exp_sel;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b1; ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_sel = (i % 2 == 1);
      #1;
      n_checks++; if (sel !== exp_sel) $display("FAIL tie_rr_sel[%0d]: got %b want %b", i, sel, exp_sel); else n_pass++;
      n_checks++; if (valid !== 1'b1) $display("FAIL tie_rr_valid[%0d]: got %b want 1", i, valid); else n_pass++;
      n_checks++; if ({grant_a, grant_b, sel, valid} !== m_vec())
        $display("FAIL tie_rr_model[%0d]: got %b want %b", i, {grant_a, grant_b, sel, valid}, m_vec()); else n_pass++;
      tick();
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0; ready = 1'b1;
    tick();
    for (int beat = 1; beat <= LOCK_LEN; beat++) begin
      last_a = (beat == LOCK_LEN);
      #1;
      n_checks++; if (sel !== 1'b0 || valid !== 1'b1)
        $display("FAIL burst_lock_beat%0d: sel=%b valid=%b want sel=0 valid=1", beat, sel, valid); else n_pass++;
      tick();
    end
    last_a = 1'b0;
    #1;
    n_checks++; if (sel !== 1'b1 || grant_b !== 1'b1)
      $display("FAIL burst_lock_switch: sel=%b grant_b=%b want 1 1", sel, grant_b); else n_pass++;
    n_checks++; if ({grant_a, grant_b, sel, valid} !== m_vec())
      $display("FAIL burst_lock_model: got %b want %b", {grant_a, grant_b, sel, valid}, m_vec()); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0; ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({grant_a, grant_b, sel, valid} !== 4'b1001)
        $display("FAIL bp_hold[%0d]: got %b want 1001", i, {grant_a, grant_b, sel, valid}); else n_pass++;
      tick();
    end
    ready = 1'b1; req_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if ({grant_a, grant_b, sel, valid} !== 4'b1000)
        $display("FAIL bp_reqdrop[%0d]: got %b want 1000", i, {grant_a, grant_b, sel, valid}); else n_pass++;
      tick();
    end
    req_a = 1'b1; last_a = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b1) $display("FAIL bp_resume_valid: got %b want 1", valid); else n_pass++;
    tick();
    last_a = 1'b0;
    #1;
    n_checks++; if (grant_b !== 1'b1 || sel !== 1'b1)
      $display("FAIL bp_handover: grant_b=%b sel=%b want 1 1", grant_b, sel); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b0; ready = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (grant_b !== 1'b1) $display("FAIL rst_mid_setup: grant_b=%b want 1", grant_b); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if ({grant_a, grant_b, sel, valid} !== 4'b0000)
      $display("FAIL rst_mid_state: got %b want 0000", {grant_a, grant_b, sel, valid}); else n_pass++;
    tick();
    #1;
    n_checks++; if (grant_a !== 1'b1 || sel !== 1'b0)
      $display("FAIL rst_mid_prio: grant_a=%b sel=%b want 1 0", grant_a, sel); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0; ready = 1'b1;
    tick();
    for (int k = 1; k <= MAXB; k++) begin
      #1;
      n_checks++; if (grant_a !== 1'b1) $display("FAIL timeout_a_beat%0d: grant_a=%b want 1", k, grant_a); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (grant_b !== TMO || grant_a !== !TMO)
      $display("FAIL timeout_switch: grant_a=%b grant_b=%b want %b %b", grant_a, grant_b, !TMO, TMO); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      n_checks++; if ({grant_a, grant_b, sel, valid} !== m_vec())
        $display("FAIL timeout_model[%0d]: got %b want %b", i, {grant_a, grant_b, sel, valid}, m_vec()); else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      last_a = ($urandom_range(0, 2) == 0);
      last_b = ($urandom_range(0, 2) == 0);
      ready  = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++; if ({grant_a, grant_b, sel, valid} !== m_vec())
        $display("FAIL random_model[%0d]: got %b want %b", i, {grant_a, grant_b, sel, valid}, m_vec()); else n_pass++;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0; ready = 1'b0;
    test_reset();
    test_tie_rr();
    test_burst_lock();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
